// File: rtl/board_row_streamer_pkg.sv
// Shared board geometry and streamer FSM encoding for the Game-of-Life datapath.
package gol_pkg;
    localparam int BOARD_ROWS = 16;
    localparam int BOARD_COLS = 16;
    localparam int BOARD_BITS = BOARD_ROWS * BOARD_COLS;
    localparam int ROW_IDX_W  = $clog2(BOARD_ROWS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/board_row_streamer_row_popcount.sv
// Combinational population count of one board row.
module row_popcount #(
    parameter int COLS = 16
) (
    input  logic [COLS-1:0]        row,
    output logic [$clog2(COLS):0]  count
);
    localparam int CW = $clog2(COLS) + 1;

    always_comb begin
        count = '0;
        for (int i = 0; i < COLS; i++)
            count = count + {{(CW-1){1'b0}}, row[i]};
    end
endmodule

// File: rtl/board_row_streamer.sv
// Captures one finished board and replays it row by row over a valid/ready stream.
// Define BOARD_ROWS_STREAMER_POPCOUNT_EN-style macro BOARD_ROW_STREAMER_POPCOUNT_EN to add row_pop/pop_count outputs.
module board_row_streamer
    import gol_pkg::*;
#(
    parameter int ROWS   = BOARD_ROWS,
    parameter int COLS   = BOARD_COLS,
    parameter int RIDX_W = ROW_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   board_valid,
    output logic                   board_ready,
    input  logic [ROWS*COLS-1:0]   board,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [COLS-1:0]        row_data,
    output logic [RIDX_W-1:0]      row_idx,
    output logic                   row_last,
    output logic                   frame_done
`ifdef BOARD_ROW_STREAMER_POPCOUNT_EN
    ,
    output logic [$clog2(ROWS*COLS):0] pop_count,
    output logic [$clog2(COLS):0]      row_pop
`endif
);
    localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);

    state_t                     state, state_n;
    logic [ROWS-1:0][COLS-1:0]  cap_q;
    logic [RIDX_W-1:0]          ridx_q;
    logic                       ready_q;
    logic                       capture, advance;

    always_comb begin
        state_n = state;
        capture = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: begin
                if (board_valid && ready_q) begin
                    capture = 1'b1;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (row_ready) begin
                    if (ridx_q == LAST_ROW) state_n = DONE;
                    else                    advance = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ready is registered from the next state so it never depends on row_ready combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cap_q   <= '0;
            ridx_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == IDLE);
            if (capture) begin
                cap_q  <= board;
                ridx_q <= '0;
            end else if (advance) begin
                ridx_q <= ridx_q + 1'b1;
            end
        end
    end

    assign board_ready = ready_q;
    assign row_valid   = (state == STREAM);
    assign row_data    = cap_q[ridx_q];
    assign row_idx     = ridx_q;
    assign row_last    = (ridx_q == LAST_ROW) && row_valid;
    assign frame_done  = (state == DONE);

`ifdef BOARD_ROW_STREAMER_POPCOUNT_EN
    localparam int POP_W = $clog2(ROWS*COLS) + 1;

    logic [POP_W-1:0] pop_q;

    row_popcount #(.COLS(COLS)) u_row_popcount (
        .row   (row_data),
        .count (row_pop)
    );

    always_ff @(posedge clk) begin
        if (rst)
            pop_q <= '0;
        else if (capture)
            pop_q <= '0;
        else if (row_valid && row_ready)
            pop_q <= pop_q + POP_W'(row_pop);
    end

    assign pop_count = pop_q;
`endif
endmodule

// File: doc/board_row_streamer.md
Name: board_row_streamer

Overview:
- Downstream of the generation-update stage.
- Captures one finished 16x16 board (256-bit vector) over a valid/ready handshake.
- Streams the board row by row to the display/render stage over a second valid/ready handshake.
- Decouples generation timing from display timing; at most one board is held at a time.

Parameters:
- ROWS, 16, number of board rows.
- COLS, 16, number of cells per row. Board width = ROWS*COLS.
- RIDX_W, 4, row index width; must equal clog2(ROWS).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- board_valid  in  1  upstream presents a complete board
- board_ready  out  1  streamer can accept a board
- board  in  ROWS*COLS  board bits; cell (r,c) = board[r*COLS + c]
- row_valid  out  1  row_data/row_idx/row_last valid
- row_ready  in  1  downstream accepts the current row
- row_data  out  COLS  row bits; row_data[c] = cell (row_idx,c)
- row_idx  out  RIDX_W  index of the current row
- row_last  out  1  high with the row ROWS-1
- frame_done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset values: board_ready=0, row_valid=0, row_data=0, row_idx=0, row_last=0, frame_done=0; internal capture register=0; state=IDLE. board_ready rises in the first cycle after rst deasserts.
- FSM has three states:
  - IDLE: board_ready=1. board_valid&&board_ready captures board into the internal register, sets row counter to 0 and goes to STREAM. Capture to first row_valid latency is 1 cycle.
  - STREAM: board_ready=0, row_valid=1. row_data is driven from the captured register at row_idx, with no combinational path from the board port.
  - On row_valid&&row_ready: if row_idx<ROWS-1, increment row_idx and stay in STREAM; else go to DONE.
  - While row_ready=0, row_data, row_idx and row_last hold stable. row_valid never drops without a handshake.
  - DONE: row_valid=0, frame_done=1 for exactly this one cycle, then return to IDLE.
- Throughput: one row per cycle when row_ready is held high. A full frame takes 1 capture + ROWS stream + 1 done = ROWS+2 cycles.
- board_ready is registered, not combinational on row_ready. A new board is never accepted mid-frame.
- row_last = (row_idx==ROWS-1) && row_valid.
- Row counter wraps to 0 on the IDLE capture; it never counts past ROWS-1.
- board changing while not captured is ignored. A board held valid across DONE is accepted in the following IDLE cycle.
- rst asserted mid-frame: the next cycle is the reset state. The partially streamed frame is discarded, with no frame_done pulse.

Optional Feature:
- Macro: BOARD_ROW_STREAMER_POPCOUNT_EN.
- Defined:
  - adds output pop_count (width clog2(ROWS*COLS)+1 = 9) and output row_pop (width clog2(COLS)+1 = 5).
  - row_pop is the number of 1 bits in the current row_data, combinational from the captured row.
  - pop_count accumulates row_pop on each row handshake and is cleared on board capture. It is valid (total live cells) from the cycle frame_done pulses until the next capture.
  - Both outputs reset to 0.
- Not defined: the ports are absent and no counting logic is built.

Decomposition:
- Shared package gol_pkg:
  - BOARD_ROWS=16, BOARD_COLS=16, BOARD_BITS=256.
  - Row-index width constant.
  - FSM state typedef (IDLE, STREAM, DONE), 2-bit encoding.
- One sub-module, row_popcount: combinational COLS-bit population counter, instantiated only under the macro.

Test Plan:
- Single frame: board with only row 0 = 16'hFFFF and row 15 = 16'h0001, row_ready=1.
  - Expected: 16 consecutive row_valid beats starting 1 cycle after capture; row 0 = FFFF, rows 1-14 = 0000, row 15 = 0001.
  - row_last only on row_idx 15; frame_done pulses once; board_ready=0 throughout.
- Backpressure: same board, row_ready toggled 1/0 and held low 5 cycles at row 7.
  - Expected: row_data/row_idx stable while stalled; all 16 rows delivered in order; none duplicated or dropped.
- Back-to-back boards: board_valid held high with board A (checkerboard 16'hAAAA/16'h5555 alternating rows), then board B (all 1s).
  - Expected: A fully streamed, frame_done, then B captured; B is never accepted during A's stream.
- Reset mid-frame: assert rst after row 5 accepted.
  - Expected: next cycle row_valid=0, row_idx=0, no frame_done; the next board streams from row 0.
- Input isolation: change the board port while streaming.
  - Expected: output rows match the captured board, not the new value.
- POPCOUNT_EN: glider board (5 live cells).
  - Expected: pop_count=5 at frame_done; row_pop matches the per-row count; all-ones board gives pop_count=256.
